// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : handshaked EX-stage ALU with iterative multiply and divide.
//
// Single-cycle ops (AND, OR, ADD, XOR, NOR, SRL, SUB, SLTU, SLL, SRA, SLT and
// the reserved code 15) register their result at the accept edge. MUL, MULHU,
// DIVU and REMU iterate one bit per cycle for WIDTH cycles. Divide by zero
// skips the iteration.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous abort of the in-flight op
//   in_valid   in   operands/op presented
//   in_ready   out  block can accept this cycle
//   in_a       in   operand A            [WIDTH]
//   in_b       in   operand B            [WIDTH]
//   in_op      in   operation code       [4]
//   out_valid  out  result available
//   out_ready  in   consumer takes result
//   out_res    out  result               [WIDTH]
//   out_zero   out  out_res == 0 (registered)
//   busy       out  iterative op in progress
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;   // counter must hold the value WIDTH itself

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_AND   = 4'd0,
        OP_OR    = 4'd1,
        OP_ADD   = 4'd2,
        OP_XOR   = 4'd3,
        OP_NOR   = 4'd4,
        OP_SRL   = 4'd5,
        OP_SUB   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_SLT   = 4'd10,
        OP_MUL   = 4'd11,
        OP_MULHU = 4'd12,
        OP_DIVU  = 4'd13,
        OP_REMU  = 4'd14,
        OP_RSV   = 4'd15
    } op_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   res_q,   res_d;
    logic               zero_q,  zero_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic [2*WIDTH-1:0] acc_q,   acc_d;    // {high, low} working register
    logic [WIDTH-1:0]   opnd_q,  opnd_d;   // multiplicand (MUL) or divisor (DIV)
    op_e                op_q,    op_d;

    logic               accept;
    logic               in_is_iter;
    logic               in_div_zero;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;

    logic               iter_is_mul;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] iter_next;
    logic [WIDTH-1:0]   iter_res;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign out_res   = res_q;
    assign out_zero  = zero_q;

    assign shamt       = in_b[SHW-1:0];   // upper B bits ignored for shifts
    assign in_is_iter  = (in_op == OP_MUL) | (in_op == OP_MULHU) |
                         (in_op == OP_DIVU) | (in_op == OP_REMU);
    assign in_div_zero = ((in_op == OP_DIVU) | (in_op == OP_REMU)) & (in_b == '0);

    // -----------------------------------------------------------------------
    // Single-cycle datapath (also supplies the divide-by-zero results)
    // -----------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        alu_res = '0;
        case (op_e'(in_op))
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_ADD:  alu_res = in_a + in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_NOR:  alu_res = ~(in_a | in_b);
            OP_SRL:  alu_res = in_a >> shamt;
            OP_SUB:  alu_res = in_a - in_b;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            OP_SLL:  alu_res = in_a << shamt;
            OP_SRA:  alu_res = $signed(in_a) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_DIVU: alu_res = '1;     // divide by zero: all ones
            OP_REMU: alu_res = in_a;   // divide by zero: dividend
            default: alu_res = '0;     // MUL/MULHU never use this; 15 is reserved
        endcase
    end

    // -----------------------------------------------------------------------
    // Iterative datapath
    // -----------------------------------------------------------------------
    // Multiply: acc = {partial, B}; each step adds A to the high half when the
    // current multiplier bit (acc[0]) is set, then shifts everything right.
    assign iter_is_mul = (op_q == OP_MUL) | (op_q == OP_MULHU);
    assign mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                         (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next    = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}. Shift one
    // dividend bit into the remainder, trial-subtract the divisor; the borrow
    // bit decides whether to keep the difference and which quotient bit to
    // shift in.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, opnd_q};
    assign div_next = rem_diff[WIDTH]
                    ? {rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                    : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign iter_next = iter_is_mul ? mul_next : div_next;
    // MUL/DIVU take the low half (product low / quotient); MULHU/REMU the high.
    assign iter_res  = ((op_q == OP_MUL) | (op_q == OP_DIVU))
                     ? iter_next[WIDTH-1:0]
                     : iter_next[2*WIDTH-1:WIDTH];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;

        if (flush) begin
            // Abort; the last result stays on out_res.
            state_d = S_IDLE;
        end else if (accept) begin
            // accept only fires from IDLE or from DONE while draining.
            if (in_is_iter & ~in_div_zero) begin
                state_d = S_BUSY;
                cnt_d   = CW'(WIDTH);
                op_d    = op_e'(in_op);
                if ((in_op == OP_MUL) | (in_op == OP_MULHU)) begin
                    opnd_d = in_a;
                    acc_d  = {{WIDTH{1'b0}}, in_b};
                end else begin
                    opnd_d = in_b;
                    acc_d  = {{WIDTH{1'b0}}, in_a};
                end
            end else begin
                state_d = S_DONE;
                res_d   = alu_res;
                zero_d  = (alu_res == '0);
            end
        end else begin
            case (state_q)
                S_BUSY: begin
                    acc_d = iter_next;
                    cnt_d = cnt_q - CW'(1);
                    // Last step: register the result straight from the
                    // final iteration.
                    if (cnt_q == CW'(1)) begin
                        state_d = S_DONE;
                        res_d   = iter_res;
                        zero_d  = (iter_res == '0);
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            zero_q  <= 1'b1;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= OP_AND;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : directed self-checking bench for alu_seq (WIDTH=32 and 8).
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam logic [3:0] OP_AND = 4'd0,  OP_OR   = 4'd1,  OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3,  OP_NOR  = 4'd4,  OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6,  OP_SLTU = 4'd7,  OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9,  OP_SLT  = 4'd10, OP_MUL  = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12, OP_DIVU = 4'd13, OP_REMU = 4'd14;
    localparam logic [3:0] OP_RSV = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n;

    // 32-bit instance
    logic        flush, in_valid, in_ready, out_valid, out_ready, out_zero, busy;
    logic [31:0] in_a, in_b, out_res;
    logic [3:0]  in_op;

    // 8-bit instance
    logic        flush8, in_valid8, in_ready8, out_valid8, out_ready8, out_zero8, busy8;
    logic [7:0]  in_a8, in_b8, out_res8;
    logic [3:0]  in_op8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_zero(out_zero), .busy(busy)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush8),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .in_op(in_op8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_res(out_res8), .out_zero(out_zero8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op, confirm it can be taken, let the accept edge pass.
    task automatic issue(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
    endtask

    // Latency counted in samples after the accept edge: 1 = visible right
    // after that edge. Iterative ops must hold busy and drop in_ready meanwhile.
    task automatic wait_res(input string tag, input logic [31:0] exp, input int exp_lat);
        int lat    = 1;
        int n_busy = 0;
        bit rdy    = 1'b0;
        while (!out_valid && lat < 200) begin
            if (busy) n_busy++;
            if (in_ready) rdy = 1'b1;
            step();
            lat++;
        end
        check({tag, "_lat"},  lat,      exp_lat);
        check({tag, "_res"},  out_res,  exp);
        check({tag, "_zero"}, out_zero, exp == 32'd0);
        if (exp_lat > 1) begin
            check({tag, "_busy_cycles"}, n_busy, exp_lat - 1);
            check({tag, "_in_ready_low"}, rdy, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;

        rst_n     = 1'b0;
        flush     = 1'b0;  in_valid  = 1'b0;  out_ready  = 1'b1;
        in_a      = '0;    in_b      = '0;    in_op      = '0;
        flush8    = 1'b0;  in_valid8 = 1'b0;  out_ready8 = 1'b1;
        in_a8     = '0;    in_b8     = '0;    in_op8     = '0;

        // Reset state
        repeat (2) step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_out_res",   out_res,   32'd0);
        check("rst_out_zero",  out_zero,  1'b1);
        check("rst_in_ready",  in_ready,  1'b1);
        rst_n = 1'b1;
        step();

        // Single-cycle ops
        issue("and",  OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0); wait_res("and",  32'h00F0_00F0, 1);
        issue("nor",  OP_NOR,  32'h0,         32'h0);         wait_res("nor",  32'hFFFF_FFFF, 1);
        issue("srl",  OP_SRL,  32'h8000_0000, 32'h0000_0021); wait_res("srl",  32'h4000_0000, 1);
        issue("sll",  OP_SLL,  32'h0000_0001, 32'h0000_003F); wait_res("sll",  32'h8000_0000, 1);
        issue("sltu", OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF); wait_res("sltu", 32'h1,         1);
        issue("rsv",  OP_RSV,  32'h1234_5678, 32'h9ABC_DEF0); wait_res("rsv",  32'h0,         1);

        // Back-to-back single-cycle ops, one result per cycle
        in_valid = 1'b1;
        in_op = OP_ADD; in_a = 32'hFFFF_FFFF; in_b = 32'h1;
        check("b2b_rdy0", in_ready, 1'b1);
        step();
        in_op = OP_SUB; in_a = 32'd5; in_b = 32'd7;
        check("b2b_add_valid", out_valid, 1'b1);
        check("b2b_add_res",   out_res,   32'h0);
        check("b2b_add_zero",  out_zero,  1'b1);
        check("b2b_rdy1",      in_ready,  1'b1);
        step();
        in_op = OP_SRA; in_a = 32'h8000_0000; in_b = 32'h24;
        check("b2b_sub_valid", out_valid, 1'b1);
        check("b2b_sub_res",   out_res,   32'hFFFF_FFFE);
        check("b2b_rdy2",      in_ready,  1'b1);
        step();
        in_op = OP_SLT; in_a = 32'hFFFF_FFFF; in_b = 32'h1;
        check("b2b_sra_valid", out_valid, 1'b1);
        check("b2b_sra_res",   out_res,   32'hF800_0000);
        check("b2b_rdy3",      in_ready,  1'b1);
        step();
        in_valid = 1'b0;
        check("b2b_slt_valid", out_valid, 1'b1);
        check("b2b_slt_res",   out_res,   32'h1);
        check("b2b_slt_zero",  out_zero,  1'b0);

        // Iterative multiply
        issue("mul",   OP_MUL,   32'h0001_0000, 32'h0001_0000); wait_res("mul",   32'h0,         33);
        issue("mulhu", OP_MULHU, 32'h0001_0000, 32'h0001_0000); wait_res("mulhu", 32'h1,         33);
        issue("mul2",  OP_MUL,   32'd12345,     32'd678);       wait_res("mul2",  32'd8369910,   33);

        // Iterative divide and divide by zero
        issue("divu",   OP_DIVU, 32'd100, 32'd7); wait_res("divu",   32'd14,        33);
        issue("remu",   OP_REMU, 32'd100, 32'd7); wait_res("remu",   32'd2,         33);
        issue("divu0",  OP_DIVU, 32'd9,   32'd0); wait_res("divu0",  32'hFFFF_FFFF, 1);
        issue("remu0",  OP_REMU, 32'd9,   32'd0); wait_res("remu0",  32'd9,         1);

        // Backpressure: result held while out_ready is low
        step();
        out_ready = 1'b0;
        issue("bp_xor", OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
        in_valid = 1'b1; in_op = OP_AND; in_a = 32'hFFFF_0000; in_b = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid",    out_valid, 1'b1);
            check("bp_res",      out_res,   32'hF00F_F00F);
            check("bp_zero",     out_zero,  1'b0);
            check("bp_in_ready", in_ready,  1'b0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        check("bp_next_valid", out_valid, 1'b1);
        check("bp_next_res",   out_res,   32'h1234_0000);

        // Flush in the middle of a divide
        issue("fl_divu", OP_DIVU, 32'd1000, 32'd3);
        repeat (9) step();
        check("fl_busy_before", busy, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_valid",    out_valid, 1'b0);
        check("fl_busy",     busy,      1'b0);
        check("fl_in_ready", in_ready,  1'b1);
        check("fl_res_kept", out_res,   32'h1234_0000);
        seen = 1'b0;
        repeat (40) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("fl_no_result", seen, 1'b0);
        issue("fl_or", OP_OR, 32'hF0, 32'h0F); wait_res("fl_or", 32'hFF, 1);

        // Asynchronous reset while busy
        step();
        issue("rb_mul", OP_MUL, 32'd3, 32'd5);
        repeat (5) step();
        check("rb_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rb_valid", out_valid, 1'b0);
        check("rb_busy",  busy,      1'b0);
        check("rb_res",   out_res,   32'd0);
        check("rb_zero",  out_zero,  1'b1);
        step();
        rst_n = 1'b1;
        step();
        issue("rb_add", OP_ADD, 32'd2, 32'd3); wait_res("rb_add", 32'd5, 1);

        // WIDTH=8 instance: MUL 15*17, latency WIDTH+1
        begin
            int lat = 1;
            in_op8 = OP_MUL; in_a8 = 8'd15; in_b8 = 8'd17; in_valid8 = 1'b1;
            check("w8_in_ready", in_ready8, 1'b1);
            step();
            in_valid8 = 1'b0;
            while (!out_valid8 && lat < 50) begin
                step();
                lat++;
            end
            check("w8_lat",  lat,       9);
            check("w8_res",  out_res8,  8'hFF);
            check("w8_zero", out_zero8, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
